uart_rx: RTL and testbench

UART receiver, the counterpart of the team's UART transmitter. It recovers 8-bit frames from the serial line:

- Frame format: start bit (0), 8 data bits LSB first, optional parity bit, one stop bit (1).
- Parity encoding matches the transmitter: `par_typ`=0 selects even, 1 selects odd.
- It oversamples the line using an internal sample-tick generator running off the single system clock.
- Results go to the parallel side as one-cycle `data_valid` pulses with error flags attached.

---
 rtl/uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx -- 8-bit UART receiver with oversampled bit recovery.
//
// Recovers frames of the form: start(0), 8 data bits LSB first, optional
// parity bit, one stop(1). Timing comes from an internal sample-tick
// generator (baud_div clk cycles per tick, OVS_RATE ticks per bit).
//
// Configuration macro: UART_RX_MAJORITY_EN
//   defined   : bit value is the 3-sample majority at samp_cnt M-1, M, M+1
//               (M = OVS_RATE/2), decided on the M+1 tick.
//   undefined : single sample at samp_cnt M, decided on the M tick.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   rx_in      in   asynchronous serial line, idles high
//   baud_div   in   [15:0] clk cycles per sample tick (0 treated as 1)
//   par_en     in   parity bit expected after data bits
//   par_typ    in   0 = even parity, 1 = odd parity
//   p_data     out  [7:0] last received byte
//   data_valid out  one-clk pulse when p_data and error flags update
//   par_err    out  parity mismatch on last frame (0 without parity)
//   stp_err    out  stop bit sampled as 0 on last frame
//   busy       out  high from start detection until frame done/aborted
module uart_rx #(
  parameter int OVS_RATE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_in,
  input  logic [15:0] baud_div,
  input  logic        par_en,
  input  logic        par_typ,
  output logic [7:0]  p_data,
  output logic        data_valid,
  output logic        par_err,
  output logic        stp_err,
  output logic        busy
);

  localparam int SW = $clog2(OVS_RATE);
  localparam logic [SW-1:0] C_LAST = SW'(OVS_RATE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [SW-1:0] C_SMP_A = SW'(OVS_RATE / 2 - 1);
  localparam logic [SW-1:0] C_SMP_B = SW'(OVS_RATE / 2);
  localparam logic [SW-1:0] C_DEC   = SW'(OVS_RATE / 2 + 1);
`else
  localparam logic [SW-1:0] C_DEC   = SW'(OVS_RATE / 2);
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic          r_rx_meta;
  logic          r_rx_s;
  logic [15:0]   r_tick_cnt;
  logic [SW-1:0] r_samp_cnt;
  logic [2:0]    r_state;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shreg;
  logic          r_par_en;
  logic          r_par_typ;
  logic          r_par_mis;

  logic [15:0]   w_div_m1;
  logic          w_tick;
  logic          w_start_det;
  logic          w_decide;
  logic          w_bit_end;
  logic          w_bit;

  // Synchronizer stage: both flops idle high so reset never looks like a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx_in;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_div_m1    = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
  // >= keeps the counter wrapping if baud_div shrinks while idle.
  assign w_tick      = (r_tick_cnt >= w_div_m1);
  assign w_start_det = (r_state == S_IDLE) && !r_rx_s;
  assign w_decide    = w_tick && (r_state != S_IDLE) && (r_samp_cnt == C_DEC);
  assign w_bit_end   = w_tick && (r_state != S_IDLE) && (r_samp_cnt == C_LAST);
  assign busy        = (r_state != S_IDLE);

  // Tick / sample counter stage: cleared on start so sampling aligns to the falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= 16'd0;
      r_samp_cnt <= '0;
    end else begin
      if (w_start_det || w_tick) r_tick_cnt <= 16'd0;
      else                       r_tick_cnt <= r_tick_cnt + 16'd1;

      if (w_start_det)                        r_samp_cnt <= '0;
      else if (w_tick && r_state != S_IDLE)   r_samp_cnt <= (r_samp_cnt == C_LAST) ? '0 : r_samp_cnt + 1'b1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic r_smp_a;
  logic r_smp_b;

  // Early samples for the vote; the third sample is the live rx_s on the decision tick.
  always_ff @(posedge clk) begin
    if (w_tick && r_samp_cnt == C_SMP_A) r_smp_a <= r_rx_s;
    if (w_tick && r_samp_cnt == C_SMP_B) r_smp_b <= r_rx_s;
  end

  assign w_bit = (r_smp_a & r_smp_b) | (r_smp_a & r_rx_s) | (r_smp_b & r_rx_s);
`else
  assign w_bit = r_rx_s;
`endif

  // Data bits land directly at their final position, so no shift direction to track.
  always_ff @(posedge clk) begin
    if (r_state == S_DATA && w_decide) r_shreg[r_bit_idx] <= w_bit;
  end

  // Frame control stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_idx  <= 3'd0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_mis  <= 1'b0;
      p_data     <= 8'h00;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state   <= S_START;
            r_bit_idx <= 3'd0;
            r_par_en  <= par_en;
            r_par_typ <= par_typ;
            r_par_mis <= 1'b0;
          end
        end
        S_START: begin
          if (w_decide && w_bit) begin
            r_state <= S_IDLE;
          end else if (w_bit_end) begin
            r_state   <= S_DATA;
            r_bit_idx <= 3'd0;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) r_state <= r_par_en ? S_PARITY : S_STOP;
            else                   r_bit_idx <= r_bit_idx + 3'd1;
          end
        end
        S_PARITY: begin
          if (w_decide)  r_par_mis <= w_bit ^ (^r_shreg) ^ r_par_typ;
          if (w_bit_end) r_state   <= S_STOP;
        end
        S_STOP: begin
          // Leave on the decision tick so a back-to-back start edge is not missed.
          if (w_decide) begin
            p_data     <= r_shreg;
            par_err    <= r_par_en & r_par_mis;
            stp_err    <= ~w_bit;
            data_valid <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- randomized self-checking bench for uart_rx.
// Frames are generated from their bit-level definition; expected byte, flags
// and data_valid timing are computed with plain arithmetic and queued.
module tb_uart_rx;

  localparam int OVS = 8;
  localparam int M   = OVS / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC_TICKS = M + 2;
`else
  localparam int DEC_TICKS = M + 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_in = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic        par_en = 1'b0;
  logic        par_typ = 1'b0;
  logic [7:0]  p_data;
  logic        data_valid;
  logic        par_err;
  logic        stp_err;
  logic        busy;

  uart_rx #(.OVS_RATE(OVS)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .baud_div(baud_div),
    .par_en(par_en), .par_typ(par_typ), .p_data(p_data),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       se;
    int         t;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_dv    = 0;
  bit   busy_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Scoreboard: every data_valid pulse is matched against the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) busy_seen = 1'b1;
    if (data_valid === 1'b1) begin
      n_dv++;
      if (exp_q.size() == 0) begin
        check("unexpected_dv", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("p_data", 32'(p_data), 32'(e.d));
        check("par_err", 32'(par_err), 32'(e.pe));
        check("stp_err", 32'(stp_err), 32'(e.se));
        check("dv_latency", cyc, e.t);
        check("busy_at_dv", 32'(busy), 0);
      end
    end
  end

  task automatic wait_bit(input int t);
    repeat (t) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_p_data"}, 32'(p_data), 0);
    check({tag, "_dv"}, 32'(data_valid), 0);
    check({tag, "_par_err"}, 32'(par_err), 0);
    check({tag, "_stp_err"}, 32'(stp_err), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Caller is 1 time unit after a rising edge. abort_bit >= 0 pulses reset
  // in the middle of that data bit and abandons the frame.
  task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop_v, input int abort_bit);
    int   de;
    int   tb;
    int   fb;
    logic pb;
    exp_t e;
    de = (baud_div == 16'd0) ? 1 : int'(baud_div);
    tb = OVS * de;
    fb = par_en ? 11 : 10;
    pb = (^d) ^ par_typ ^ flip;
    e.d  = d;
    e.pe = par_en & flip;
    e.se = ~stop_v;
    // 3 clk: two synchronizer flops plus the IDLE detection edge.
    e.t  = cyc + 3 + (fb - 1) * tb + DEC_TICKS * de;
    if (abort_bit < 0) exp_q.push_back(e);
    rx_in = 1'b0;
    wait_bit(tb);
    check("busy_in_frame", 32'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      if (i == abort_bit) begin
        idle(tb / 2);
        rst = 1'b1;
        rx_in = 1'b1;
        idle(1);
        check_reset_outputs("midrst");
        rst = 1'b0;
        return;
      end
      wait_bit(tb);
    end
    if (par_en) begin
      rx_in = pb;
      wait_bit(tb);
    end
    rx_in = stop_v;
    wait_bit(tb);
    rx_in = 1'b1;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dv0;
    int gap;
    int de;
    logic [7:0] d;
    bit flip;
    bit stop_v;

    idle(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(5);

    // No parity.
    par_en = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    idle(40);
    check("busy_after_a5", 32'(busy), 0);

    // Even parity, correct then wrong parity bit.
    par_en = 1'b1; par_typ = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    idle(20);
    send_frame(8'h3C, 1'b1, 1'b1, -1);
    idle(20);

    // Odd parity, then two frames with no idle gap.
    par_typ = 1'b1;
    send_frame(8'h01, 1'b0, 1'b1, -1);
    idle(20);
    send_frame(8'h55, 1'b0, 1'b1, -1);
    send_frame(8'hAA, 1'b0, 1'b1, -1);
    idle(40);

    // Framing error, then a clean frame clears stp_err.
    par_en = 1'b0;
    send_frame(8'hF0, 1'b0, 1'b0, -1);
    idle(100);
    send_frame(8'h0F, 1'b0, 1'b1, -1);
    idle(40);

    // Glitch rejection.
    dv0 = n_dv;
    busy_seen = 1'b0;
    rx_in = 1'b0;
    idle(8);
    rx_in = 1'b1;
    idle(80);
    check("glitch_busy_seen", 32'(busy_seen), 1);
    check("glitch_busy_low", 32'(busy), 0);
    check("glitch_no_dv", n_dv, dv0);
    check("glitch_hold_p_data", 32'(p_data), 32'h0F);

    // Reset during data bit 4, then a clean frame.
    dv0 = n_dv;
    send_frame(8'h5A, 1'b0, 1'b1, 4);
    idle(200);
    check("midrst_no_dv", n_dv, dv0);
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    idle(40);

    // Randomized frames with varying divider, parity and errors.
    for (int k = 0; k < 30; k++) begin
      baud_div = 16'($urandom_range(0, 4));
      par_en   = 1'($urandom_range(0, 1));
      par_typ  = 1'($urandom_range(0, 1));
      d        = 8'($urandom);
      flip     = ($urandom_range(0, 3) == 0);
      stop_v   = ($urandom_range(0, 4) != 0);
      de       = (baud_div == 16'd0) ? 1 : int'(baud_div);
      send_frame(d, flip, stop_v, -1);
      // A low stop bit leaves the line low into IDLE, so allow the false start to clear.
      gap = stop_v ? $urandom_range(0, 2) * OVS * de : 3 * OVS * de + 10;
      if (gap > 0) idle(gap);
    end

    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    idle(4);
    check("all_frames_seen", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
